// File: rtl/thread_scheduler.sv
// ---------------------------------------------------------------------------
// thread_scheduler
//
// Per-thread fetch scheduler. Each hardware thread runs a small FSM
// (IDLE / READY / MISS / FLUSH). A registered round-robin picker selects one
// READY, enabled thread per cycle for instruction fetch.
//
// Optional feature (compile-time macro THREAD_SCHED_TIMEOUT_EN):
//   when defined, a thread sitting in MISS for MISS_TIMEOUT cycles without a
//   fill_done returns to READY so the fetch is retried. When undefined, a MISS
//   thread waits for fill_done indefinitely and no timeout counters exist.
//
// Parameters
//   N_THREADS     number of hardware threads (TW = clog2(N_THREADS))
//   FLUSH_CYCLES  cycles a thread spends in FLUSH after an invalidate
//   MISS_TIMEOUT  miss-wait limit (only with THREAD_SCHED_TIMEOUT_EN)
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   thread_en     per-thread enable; a disabled thread is forced to IDLE
//   stall         freeze selection outputs and round-robin pointer
//   miss_valid    miss reported on miss_thread
//   fill_done     miss on fill_thread serviced
//   inv_en        invalidate history of inv_thread (enter FLUSH)
//   sel_valid     sel_thread is a fetchable thread
//   sel_thread    thread to fetch this cycle
//   thread_state  per-thread state code, thread i at [2i+1:2i]
// ---------------------------------------------------------------------------
module thread_scheduler #(
   parameter int  N_THREADS    = 4,
   parameter int  FLUSH_CYCLES = 5,
   parameter int  MISS_TIMEOUT = 64,
   localparam int TW           = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_THREADS-1:0]   thread_en,
   input  logic                   stall,
   input  logic                   miss_valid,
   input  logic [TW-1:0]          miss_thread,
   input  logic                   fill_done,
   input  logic [TW-1:0]          fill_thread,
   input  logic                   inv_en,
   input  logic [TW-1:0]          inv_thread,
   output logic                   sel_valid,
   output logic [TW-1:0]          sel_thread,
   output logic [2*N_THREADS-1:0] thread_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      MISS  = 2'd2,
      FLUSH = 2'd3
   } tstate_e;

   localparam int             FCW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

`ifdef THREAD_SCHED_TIMEOUT_EN
   localparam int             MCW        = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT) : 1;
   localparam logic [MCW-1:0] MISS_LOAD  = MCW'(MISS_TIMEOUT - 1);
`endif

   tstate_e              st_q   [N_THREADS];
   tstate_e              st_d   [N_THREADS];
   logic [FCW-1:0]       fcnt_q [N_THREADS];
   logic [FCW-1:0]       fcnt_d [N_THREADS];
`ifdef THREAD_SCHED_TIMEOUT_EN
   logic [MCW-1:0]       mcnt_q [N_THREADS];
   logic [MCW-1:0]       mcnt_d [N_THREADS];
`endif

   logic [N_THREADS-1:0] inv_hit;
   logic [N_THREADS-1:0] miss_hit;
   logic [N_THREADS-1:0] fill_hit;

   // Stage p0: decode events and compute next thread states.
   always_comb begin
      for (int i = 0; i < N_THREADS; i++) begin
         inv_hit[i]  = inv_en     && (inv_thread  == TW'(i));
         miss_hit[i] = miss_valid && (miss_thread == TW'(i));
         fill_hit[i] = fill_done  && (fill_thread == TW'(i));
      end
   end

   always_comb begin
      for (int i = 0; i < N_THREADS; i++) begin
         st_d[i]   = st_q[i];
         fcnt_d[i] = fcnt_q[i];
`ifdef THREAD_SCHED_TIMEOUT_EN
         mcnt_d[i] = mcnt_q[i];
`endif
         if (!thread_en[i]) begin
            st_d[i]   = IDLE;
            fcnt_d[i] = '0;
`ifdef THREAD_SCHED_TIMEOUT_EN
            mcnt_d[i] = '0;
`endif
         end else if (st_q[i] == IDLE) begin
            // Events on an IDLE thread are ignored; it simply wakes up.
            st_d[i] = READY;
         end else if (inv_hit[i]) begin
            st_d[i]   = FLUSH;
            fcnt_d[i] = FLUSH_LOAD;
         end else if (miss_hit[i] && (st_q[i] == READY || st_q[i] == MISS)) begin
            // Miss outranks a same-cycle fill, so the thread stays in MISS.
            st_d[i] = MISS;
`ifdef THREAD_SCHED_TIMEOUT_EN
            mcnt_d[i] = MISS_LOAD;
`endif
         end else if (fill_hit[i] && st_q[i] == MISS) begin
            st_d[i] = READY;
         end else if (st_q[i] == FLUSH) begin
            // Counter is loaded with FLUSH_CYCLES-1 so FLUSH lasts FLUSH_CYCLES.
            if (fcnt_q[i] == '0) begin
               st_d[i] = READY;
            end else begin
               fcnt_d[i] = fcnt_q[i] - 1'b1;
            end
`ifdef THREAD_SCHED_TIMEOUT_EN
         end else if (st_q[i] == MISS) begin
            if (mcnt_q[i] == '0) begin
               st_d[i] = READY;
            end else begin
               mcnt_d[i] = mcnt_q[i] - 1'b1;
            end
`else
         end else if (st_q[i] == MISS) begin
            // Without the timeout a miss is only cleared by fill_done.
            st_d[i] = MISS;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_THREADS; i++) begin
            st_q[i]   <= IDLE;
            fcnt_q[i] <= '0;
`ifdef THREAD_SCHED_TIMEOUT_EN
            mcnt_q[i] <= '0;
`endif
         end
      end else begin
         for (int i = 0; i < N_THREADS; i++) begin
            st_q[i]   <= st_d[i];
            fcnt_q[i] <= fcnt_d[i];
`ifdef THREAD_SCHED_TIMEOUT_EN
            mcnt_q[i] <= mcnt_d[i];
`endif
         end
      end
   end

   always_comb begin
      thread_state = '0;
      for (int i = 0; i < N_THREADS; i++) begin
         thread_state[2*i +: 2] = st_q[i];
      end
   end

   // Stage p0: round-robin search over threads eligible before the edge.
   logic [TW-1:0]        last_sel_q;
   logic [N_THREADS-1:0] elig_p0;
   logic                 found_p0;
   logic [TW-1:0]        pick_p0;
   int                   idx_p0;

   always_comb begin
      found_p0 = 1'b0;
      pick_p0  = '0;
      idx_p0   = 0;
      for (int i = 0; i < N_THREADS; i++) begin
         elig_p0[i] = thread_en[i] && (st_q[i] == READY);
      end
      // Search order last_sel+1, last_sel+2, ... modulo N_THREADS.
      for (int k = 0; k < N_THREADS; k++) begin
         idx_p0 = (int'(last_sel_q) + 1 + k) % N_THREADS;
         if (!found_p0 && elig_p0[idx_p0]) begin
            found_p0 = 1'b1;
            pick_p0  = TW'(idx_p0);
         end
      end
   end

   // Stage p1: registered selection.
   logic          vld_p1;
   logic [TW-1:0] sel_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1     <= 1'b0;
         sel_p1     <= '0;
         // Start one below zero so thread 0 is searched first.
         last_sel_q <= TW'(N_THREADS - 1);
      end else if (!stall) begin
         if (found_p0) begin
            vld_p1     <= 1'b1;
            sel_p1     <= pick_p0;
            last_sel_q <= pick_p0;
         end else begin
            vld_p1     <= 1'b0;
         end
      end
   end

   assign sel_valid  = vld_p1;
   assign sel_thread = sel_p1;

endmodule

// File: tb/tb_thread_scheduler.sv
// ---------------------------------------------------------------------------
// tb_thread_scheduler
//
// Directed bench for thread_scheduler. A behavioural model (per-thread state
// plus "cycles left" counters and a round-robin pointer) predicts outputs and
// is compared every cycle; directed sections add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_thread_scheduler;

   localparam int N  = 4;
   localparam int FC = 5;
   localparam int MT = 64;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] thread_en = '0;
   logic         stall = 1'b0;
   logic         miss_valid = 1'b0;
   logic [1:0]   miss_thread = '0;
   logic         fill_done = 1'b0;
   logic [1:0]   fill_thread = '0;
   logic         inv_en = 1'b0;
   logic [1:0]   inv_thread = '0;
   logic         sel_valid;
   logic [1:0]   sel_thread;
   logic [2*N-1:0] thread_state;

   always #5 clk = ~clk;

   thread_scheduler #(
      .N_THREADS   (N),
      .FLUSH_CYCLES(FC),
      .MISS_TIMEOUT(MT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .thread_en   (thread_en),
      .stall       (stall),
      .miss_valid  (miss_valid),
      .miss_thread (miss_thread),
      .fill_done   (fill_done),
      .fill_thread (fill_thread),
      .inv_en      (inv_en),
      .inv_thread  (inv_thread),
      .sel_valid   (sel_valid),
      .sel_thread  (sel_thread),
      .thread_state(thread_state)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // m_st: 0 idle, 1 ready, 2 miss, 3 flush. m_fl/m_mc: cycles still to spend.
   int m_st [N];
   int m_fl [N];
   int m_mc [N];
   int m_last;
   int m_sel;
   int m_vld;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_st[i] = 0;
         m_fl[i] = 0;
         m_mc[i] = 0;
      end
      m_last = N - 1;
      m_sel  = 0;
      m_vld  = 0;
   endfunction

   function automatic void model_step();
      int  pick;
      int  j;
      bit  found;
      bit  inv_i;
      bit  miss_i;
      bit  fill_i;
      if (!stall) begin
         found = 1'b0;
         pick  = 0;
         for (int k = 1; k <= N; k++) begin
            j = (m_last + k) % N;
            if (!found && m_st[j] == 1 && thread_en[j]) begin
               found = 1'b1;
               pick  = j;
            end
         end
         if (found) begin
            m_vld  = 1;
            m_sel  = pick;
            m_last = pick;
         end else begin
            m_vld = 0;
         end
      end
      for (int i = 0; i < N; i++) begin
         inv_i  = inv_en     && (int'(inv_thread)  == i);
         miss_i = miss_valid && (int'(miss_thread) == i);
         fill_i = fill_done  && (int'(fill_thread) == i);
         if (!thread_en[i]) begin
            m_st[i] = 0;
            m_fl[i] = 0;
            m_mc[i] = 0;
         end else if (m_st[i] == 0) begin
            m_st[i] = 1;
         end else if (inv_i) begin
            m_st[i] = 3;
            m_fl[i] = FC;
         end else if (miss_i && m_st[i] != 3) begin
            m_st[i] = 2;
            m_mc[i] = MT;
         end else if (fill_i && m_st[i] == 2) begin
            m_st[i] = 1;
         end else if (m_st[i] == 3) begin
            m_fl[i] = m_fl[i] - 1;
            if (m_fl[i] == 0) m_st[i] = 1;
`ifdef THREAD_SCHED_TIMEOUT_EN
         end else if (m_st[i] == 2) begin
            m_mc[i] = m_mc[i] - 1;
            if (m_mc[i] == 0) m_st[i] = 1;
`endif
         end
      end
   endfunction

   function automatic int model_state();
      int v = 0;
      for (int i = 0; i < N; i++) v = v | (m_st[i] << (2 * i));
      return v;
   endfunction

   always @(posedge clk) if (rst === 1'b1) model_step();
   always @(negedge rst) model_reset();

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en && rst === 1'b1) begin
         check("model_sel_valid",    int'(sel_valid),    m_vld);
         check("model_sel_thread",   int'(sel_thread),   m_sel);
         check("model_thread_state", int'(thread_state), model_state());
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int rr [5];
      int held;
      bit seen;
      rr = '{0, 1, 2, 3, 0};
      model_reset();

      @(negedge clk);
      check("reset_state", int'(thread_state), 0);
      check("reset_valid", int'(sel_valid), 0);
      check("reset_sel",   int'(sel_thread), 0);
      rst    = 1'b1;
      chk_en = 1'b1;
      cyc(1);
      thread_en = 4'hF;
      cyc(1);
      check("wake_state", int'(thread_state), 8'h55);
      check("wake_valid", int'(sel_valid), 0);

      // Round robin from thread 0.
      for (int k = 0; k < 5; k++) begin
         cyc(1);
         check("rr_sel",   int'(sel_thread), rr[k]);
         check("rr_valid", int'(sel_valid), 1);
      end

      // Miss on thread 1, then fill.
      miss_valid = 1'b1; miss_thread = 2'd1;
      cyc(1);
      miss_valid = 1'b0;
      check("miss_state1", int'(thread_state[3:2]), 2);
      check("miss_edge_sel", int'(sel_thread), 1);
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         check("miss_excluded", int'(sel_thread == 2'd1), 0);
      end
      fill_done = 1'b1; fill_thread = 2'd1;
      cyc(1);
      fill_done = 1'b0;
      check("fill_state1", int'(thread_state[3:2]), 1);
      seen = 1'b0;
      for (int k = 0; k < N && !seen; k++) begin
         cyc(1);
         if (sel_valid && sel_thread == 2'd1) seen = 1'b1;
      end
      check("fill_reselect", int'(seen), 1);

      // Flush on thread 2: exactly FC cycles.
      inv_en = 1'b1; inv_thread = 2'd2;
      cyc(1);
      inv_en = 1'b0;
      check("flush_c1", int'(thread_state[5:4]), 3);
      for (int k = 2; k <= 6; k++) begin
         cyc(1);
         check("flush_len", int'(thread_state[5:4]), (k <= FC) ? 3 : 1);
      end

      // Flush re-armed at flush cycle 3.
      inv_en = 1'b1; inv_thread = 2'd2;
      cyc(1);
      inv_en = 1'b0;
      cyc(2);
      check("reflush_c3", int'(thread_state[5:4]), 3);
      inv_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc(1);
         inv_en = 1'b0;
         check("reflush_len", int'(thread_state[5:4]), (k < FC) ? 3 : 1);
      end

      // Collisions on thread 0.
      miss_valid = 1'b1; miss_thread = 2'd0;
      fill_done  = 1'b1; fill_thread = 2'd0;
      cyc(1);
      miss_valid = 1'b0;
      check("coll_miss_fill", int'(thread_state[1:0]), 2);
      cyc(1);
      fill_done = 1'b0;
      check("coll_fill_after", int'(thread_state[1:0]), 1);
      miss_valid = 1'b1; fill_done = 1'b1; inv_en = 1'b1; inv_thread = 2'd0;
      cyc(1);
      miss_valid = 1'b0; fill_done = 1'b0; inv_en = 1'b0;
      check("coll_inv", int'(thread_state[1:0]), 3);
      cyc(5);
      check("coll_inv_done", int'(thread_state[1:0]), 1);

      // Fill on a READY thread is ignored.
      fill_done = 1'b1; fill_thread = 2'd3;
      cyc(1);
      fill_done = 1'b0;
      check("fill_ignored", int'(thread_state[7:6]), 1);

      // thread_en overrides a same-cycle invalidate.
      thread_en = 4'b1011; inv_en = 1'b1; inv_thread = 2'd2;
      cyc(1);
      inv_en = 1'b0; thread_en = 4'hF;
      check("disable_idle", int'(thread_state[5:4]), 0);
      cyc(1);
      check("reenable_ready", int'(thread_state[5:4]), 1);

      // Stall holds the selection.
      cyc(1);
      held  = m_sel;
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         check("stall_hold", int'(sel_thread), held);
      end
      stall = 1'b0;

      // All threads in MISS -> nothing selectable.
      for (int t = 0; t < N; t++) begin
         miss_valid = 1'b1; miss_thread = 2'(t);
         cyc(1);
      end
      miss_valid = 1'b0;
      cyc(2);
      check("allmiss_state", int'(thread_state), 8'hAA);
      check("allmiss_valid", int'(sel_valid), 0);
`ifndef THREAD_SCHED_TIMEOUT_EN
      cyc(100);
      check("no_timeout_t3", int'(thread_state[7:6]), 2);
`endif
      for (int t = 0; t < N; t++) begin
         fill_done = 1'b1; fill_thread = 2'(t);
         cyc(1);
      end
      fill_done = 1'b0;
      cyc(1);
      check("allfill_state", int'(thread_state), 8'h55);

      // Asynchronous reset in the middle of a flush.
      inv_en = 1'b1; inv_thread = 2'd1;
      miss_valid = 1'b1; miss_thread = 2'd3;
      cyc(1);
      inv_en = 1'b0; miss_valid = 1'b0;
      cyc(1);
      check("pre_reset_flush", int'(thread_state[3:2]), 3);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_state", int'(thread_state), 0);
      check("async_rst_valid", int'(sel_valid), 0);
      check("async_rst_sel",   int'(sel_thread), 0);
      @(negedge clk);
      rst = 1'b1;
      cyc(1);
      check("post_rst_state", int'(thread_state), 8'h55);
      cyc(1);
      check("post_rst_sel",   int'(sel_thread), 0);
      check("post_rst_valid", int'(sel_valid), 1);
      cyc(3);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
